hazard_unit: RTL and testbench



---
 rtl/hazard_unit.sv | 175 +++++++++++++++++
 tb/tb_hazard_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Five-stage MIPS hazard controller: Tuse/Tnew stall detection and forwarding selects.
// Define HAZARD_STALL_CNT_EN to add the saturating stall_cnt output.
module hazard_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic        jreg_D,
    input  logic [4:0]  dst_D,
    input  logic [1:0]  tnew_D,
    output logic        stall,
    output logic        flush_E,
    output logic [1:0]  forward_rs_b,
    output logic [1:0]  forward_rt_b,
    output logic [1:0]  forward_rs_jr,
    output logic [1:0]  forward_rt_ji,
    output logic [1:0]  forward_rs_alu,
    output logic [1:0]  forward_rt_alu,
    output logic        forward_rt_mem
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    logic [4:0] rs_E_r, rt_E_r, dst_E_r, rt_M_r, dst_M_r, dst_W_r;
    logic [1:0] tnew_E_r, tnew_M_r;
    logic       stall_s;

    function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : (t - 2'd1);
    endfunction

    // The compare muxes have no E-stage path, so a ready E result still stalls them.
    function automatic logic need_stall(input logic [4:0] src, input logic [1:0] tuse,
                                        input logic [4:0] de, input logic [1:0] te,
                                        input logic [4:0] dm, input logic [1:0] tm,
                                        input logic jreg);
        logic res;
        res = 1'b0;
        if (tuse == 2'd3) begin
            res = 1'b0;
        end else if (hit(src, de)) begin
            res = (te > tuse) || ((te == 2'd0) && (tuse == 2'd0) && !jreg);
        end else if (hit(src, dm)) begin
            res = (tm > tuse);
        end else begin
            res = 1'b0;
        end
        return res;
    endfunction

    function automatic logic [1:0] sel_b(input logic [4:0] src, input logic [4:0] de,
                                         input logic [4:0] dm, input logic [1:0] tm,
                                         input logic [4:0] dw);
        logic [1:0] res;
        res = 2'd0;
        if (hit(src, de)) begin
            res = 2'd0;
        end else if (hit(src, dm)) begin
            res = (tm == 2'd0) ? 2'd1 : 2'd0;
        end else if (hit(src, dw)) begin
            res = 2'd2;
        end else begin
            res = 2'd0;
        end
        return res;
    endfunction

    function automatic logic [1:0] sel_jr(input logic [4:0] src, input logic [4:0] de,
                                          input logic [1:0] te, input logic [4:0] dm,
                                          input logic [1:0] tm, input logic [4:0] dw);
        logic [1:0] res;
        res = 2'd0;
        if (hit(src, de)) begin
            res = (te == 2'd0) ? 2'd1 : 2'd0;
        end else if (hit(src, dm)) begin
            res = (tm == 2'd0) ? 2'd2 : 2'd0;
        end else if (hit(src, dw)) begin
            res = 2'd3;
        end else begin
            res = 2'd0;
        end
        return res;
    endfunction

    function automatic logic [1:0] sel_alu(input logic [4:0] src, input logic [4:0] dm,
                                           input logic [1:0] tm, input logic [4:0] dw);
        logic [1:0] res;
        res = 2'd0;
        if (hit(src, dm)) begin
            res = (tm == 2'd0) ? 2'd1 : 2'd0;
        end else if (hit(src, dw)) begin
            res = 2'd2;
        end else begin
            res = 2'd0;
        end
        return res;
    endfunction

    // Stall decision; masked while reset is asserted so the bubble logic stays idle.
    always_comb begin
        stall_s = 1'b0;
        if (reset) begin
            stall_s = 1'b0;
        end else begin
            stall_s = need_stall(rs_D, tuse_rs_D, dst_E_r, tnew_E_r, dst_M_r, tnew_M_r, jreg_D)
                   || need_stall(rt_D, tuse_rt_D, dst_E_r, tnew_E_r, dst_M_r, tnew_M_r, jreg_D);
        end
    end

    assign stall          = stall_s;
    assign flush_E        = stall_s;
    assign forward_rs_b   = sel_b(rs_D, dst_E_r, dst_M_r, tnew_M_r, dst_W_r);
    assign forward_rt_b   = sel_b(rt_D, dst_E_r, dst_M_r, tnew_M_r, dst_W_r);
    assign forward_rs_jr  = sel_jr(rs_D, dst_E_r, tnew_E_r, dst_M_r, tnew_M_r, dst_W_r);
    assign forward_rt_ji  = sel_jr(rt_D, dst_E_r, tnew_E_r, dst_M_r, tnew_M_r, dst_W_r);
    assign forward_rs_alu = sel_alu(rs_E_r, dst_M_r, tnew_M_r, dst_W_r);
    assign forward_rt_alu = sel_alu(rt_E_r, dst_M_r, tnew_M_r, dst_W_r);
    assign forward_rt_mem = hit(rt_M_r, dst_W_r);

    // Pipeline advance: D->E (bubble on stall), E->M with Tnew countdown, M->W.
    always_ff @(posedge clk) begin
        if (reset) begin
            rs_E_r   <= 5'd0;
            rt_E_r   <= 5'd0;
            dst_E_r  <= 5'd0;
            tnew_E_r <= 2'd0;
            rt_M_r   <= 5'd0;
            dst_M_r  <= 5'd0;
            tnew_M_r <= 2'd0;
            dst_W_r  <= 5'd0;
        end else begin
            dst_W_r  <= dst_M_r;
            rt_M_r   <= rt_E_r;
            dst_M_r  <= dst_E_r;
            tnew_M_r <= sat_dec(tnew_E_r);
            if (stall_s) begin
                rs_E_r   <= 5'd0;
                rt_E_r   <= 5'd0;
                dst_E_r  <= 5'd0;
                tnew_E_r <= 2'd0;
            end else begin
                rs_E_r   <= rs_D;
                rt_E_r   <= rt_D;
                dst_E_r  <= dst_D;
                tnew_E_r <= tnew_D;
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: hand-derived expected selects queued per D-stage vector.
module tb_hazard_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_D, rt_D, dst_D;
    logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_D;
    logic        jreg_D;
    logic        stall, flush_E, forward_rt_mem;
    logic [1:0]  forward_rs_b, forward_rt_b, forward_rs_jr, forward_rt_ji;
    logic [1:0]  forward_rs_alu, forward_rt_alu;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    typedef struct packed {
        logic       stall;
        logic [1:0] b_rs;
        logic [1:0] b_rt;
        logic [1:0] jr;
        logic [1:0] ji;
        logic [1:0] alu_rs;
        logic [1:0] alu_rt;
        logic       mem;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec;
    int   n_err;
    int   exp_stalls;

    hazard_unit dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
        .jreg_D(jreg_D), .dst_D(dst_D), .tnew_D(tnew_D),
        .stall(stall), .flush_E(flush_E),
        .forward_rs_b(forward_rs_b), .forward_rt_b(forward_rt_b),
        .forward_rs_jr(forward_rs_jr), .forward_rt_ji(forward_rt_ji),
        .forward_rs_alu(forward_rs_alu), .forward_rt_alu(forward_rt_alu),
        .forward_rt_mem(forward_rt_mem)
`ifdef HAZARD_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic exp_t mk(input int s, input int brs, input int brt, input int jr,
                                input int ji, input int ars, input int art, input int mem);
        exp_t e;
        e.stall  = s[0];
        e.b_rs   = brs[1:0];
        e.b_rt   = brt[1:0];
        e.jr     = jr[1:0];
        e.ji     = ji[1:0];
        e.alu_rs = ars[1:0];
        e.alu_rt = art[1:0];
        e.mem    = mem[0];
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        e = sb_q.pop_front();
        check_val("stall",          32'(stall),          32'(e.stall));
        check_val("flush_E",        32'(flush_E),        32'(e.stall));
        check_val("forward_rs_b",   32'(forward_rs_b),   32'(e.b_rs));
        check_val("forward_rt_b",   32'(forward_rt_b),   32'(e.b_rt));
        check_val("forward_rs_jr",  32'(forward_rs_jr),  32'(e.jr));
        check_val("forward_rt_ji",  32'(forward_rt_ji),  32'(e.ji));
        check_val("forward_rs_alu", 32'(forward_rs_alu), 32'(e.alu_rs));
        check_val("forward_rt_alu", 32'(forward_rt_alu), 32'(e.alu_rt));
        check_val("forward_rt_mem", 32'(forward_rt_mem), 32'(e.mem));
    endtask

    // One D-stage vector per cycle; outputs sampled mid low phase, before the next rising edge.
    task automatic step(input int rst, input int rs, input int trs, input int rt, input int trt,
                        input int jr, input int dst, input int tn, input exp_t e);
        @(negedge clk);
        reset     = rst[0];
        rs_D      = rs[4:0];
        tuse_rs_D = trs[1:0];
        rt_D      = rt[4:0];
        tuse_rt_D = trt[1:0];
        jreg_D    = jr[0];
        dst_D     = dst[4:0];
        tnew_D    = tn[1:0];
        sb_q.push_back(e);
        if (rst != 0) exp_stalls = 0;
        else if (e.stall) exp_stalls++;
        #2;
        compare_out();
    endtask

    task automatic nop(input exp_t e);
        step(0, 0, 3, 0, 3, 0, 0, 0, e);
    endtask

    initial begin
        exp_t z;
        n_vec = 0; n_err = 0; exp_stalls = 0;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1; rs_D = 5'd0; rt_D = 5'd0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
        jreg_D = 1'b0; dst_D = 5'd0; tnew_D = 2'd0;

        // reset with an ALU write of $5 pending, then observe it reach E
        step(1, 0, 3, 0, 3, 0, 5, 1, z);
        step(0, 0, 3, 0, 3, 0, 5, 1, z);
        step(0, 5, 0, 0, 3, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));
        step(0, 5, 0, 0, 3, 0, 0, 0, mk(0, 1, 0, 2, 0, 0, 0, 0));
        nop(mk(0, 0, 0, 0, 0, 2, 0, 0));
        nop(z);

        // reset in the middle of a load-use stall discards the hazard
        step(0, 0, 3, 0, 3, 0, 9, 2, z);
        step(1, 9, 1, 0, 3, 0, 0, 0, z);
        step(0, 9, 1, 0, 3, 0, 0, 0, z);
        nop(z);
        nop(z);

        // ALU producer $8 then two ALU consumers
        step(0, 0, 3, 0, 3, 0, 8, 1, z);
        step(0, 8, 1, 0, 3, 0, 0, 0, z);
        step(0, 0, 3, 8, 1, 0, 0, 0, mk(0, 0, 1, 0, 2, 1, 0, 0));
        nop(mk(0, 0, 0, 0, 0, 0, 2, 0));
        nop(z);
        nop(z);

        // load $9, ALU consumer on rt: one stall
        step(0, 0, 3, 0, 3, 0, 9, 2, z);
        step(0, 0, 3, 9, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 3, 9, 1, 0, 0, 0, z);
        nop(mk(0, 0, 0, 0, 0, 0, 2, 0));
        nop(z);
        nop(z);

        // jal $31 then jr $31
        step(0, 0, 3, 0, 3, 0, 31, 0, z);
        step(0, 31, 0, 0, 3, 1, 0, 0, mk(0, 0, 0, 1, 0, 0, 0, 0));
        nop(mk(0, 0, 0, 0, 0, 1, 0, 0));
        nop(z);
        nop(z);

        // jal $31 then beq on $31: one stall
        step(0, 0, 3, 0, 3, 0, 31, 0, z);
        step(0, 31, 0, 0, 3, 0, 0, 0, mk(1, 0, 0, 1, 0, 0, 0, 0));
        step(0, 31, 0, 0, 3, 0, 0, 0, mk(0, 1, 0, 2, 0, 0, 0, 0));
        nop(mk(0, 0, 0, 0, 0, 2, 0, 0));
        nop(z);
        nop(z);

        // $0 is never a hazard
        step(0, 0, 3, 0, 3, 0, 0, 2, z);
        step(0, 0, 0, 0, 0, 0, 0, 2, z);
        nop(z);
        nop(z);

        // load $4 then store of $4: write_data forwarded into M
        step(0, 0, 3, 0, 3, 0, 4, 2, z);
        step(0, 0, 3, 4, 2, 0, 0, 0, z);
        nop(z);
        nop(mk(0, 0, 0, 0, 0, 0, 0, 1));
        nop(z);

        // load $9 then beq on $9: two stalls
        step(0, 0, 3, 0, 3, 0, 9, 2, z);
        step(0, 9, 0, 0, 3, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));
        step(0, 9, 0, 0, 3, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));
        step(0, 9, 0, 0, 3, 0, 0, 0, mk(0, 2, 0, 3, 0, 0, 0, 0));
        nop(z);

`ifdef HAZARD_STALL_CNT_EN
        @(negedge clk);
        #2;
        check_val("stall_cnt", stall_cnt, 32'(exp_stalls));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
